// File: rtl/tile_sched_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_sched_pkg
// Description : Shared types and helpers for the GEMM tile scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_sched_pkg;

    localparam int c_tidx_w_def = 8;

    typedef logic [c_tidx_w_def-1:0] tidx_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } sched_state_e;

    // A zero-length or over-long reduction cannot be scheduled.
    function automatic logic k_len_bad(input logic [15:0] k_len, input logic [31:0] kmax);
        return (k_len == 16'd0) || (32'(k_len) > kmax);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_sched_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tile_sched_ctrl_if
// Description : Command, status and engine handshake bundle of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface tile_sched_ctrl_if
    import tpu_sched_pkg::*;
#(
    parameter int TIDX_W = c_tidx_w_def
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [TIDX_W-1:0] cmd_num_tm;
    logic [TIDX_W-1:0] cmd_num_tn;
    logic [15:0]       cmd_K_len;
    logic              busy;
    logic              done;
    logic              err;
    logic              load_start;
    logic [15:0]       load_K_len;
    logic              load_buf;
    logic [TIDX_W-1:0] load_tm;
    logic [TIDX_W-1:0] load_tn;
    logic              load_done;
    logic              cmp_start;
    logic              cmp_buf;
    logic              cmp_done;
    logic              st_start;
    logic [TIDX_W-1:0] st_tm;
    logic [TIDX_W-1:0] st_tn;
    logic              st_done;

    // Scheduler side.
    modport master (
        input  cmd_valid, cmd_num_tm, cmd_num_tn, cmd_K_len,
        input  load_done, cmp_done, st_done,
        output cmd_ready, busy, done, err,
        output load_start, load_K_len, load_buf, load_tm, load_tn,
        output cmp_start, cmp_buf,
        output st_start, st_tm, st_tn
    );

    // Command issuer and engine side.
    modport slave (
        output cmd_valid, cmd_num_tm, cmd_num_tn, cmd_K_len,
        output load_done, cmp_done, st_done,
        input  cmd_ready, busy, done, err,
        input  load_start, load_K_len, load_buf, load_tm, load_tn,
        input  cmp_start, cmp_buf,
        input  st_start, st_tm, st_tn
    );

endinterface
`default_nettype wire

// File: rtl/tile_sched_ctrl_eng_slot.sv
`default_nettype none
// ============================================================================
// Module      : sched_eng_slot
// Description : Per-engine start pulse, outstanding flag and completed-tile counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sched_eng_slot
    import tpu_sched_pkg::*;
#(
    parameter int CNT_W = 2 * c_tidx_w_def
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_issue,
    input  logic             i_done,
    output logic             o_start,
    output logic             o_busy,
    output logic             o_ack,
    output logic [CNT_W-1:0] o_cnt
);

    logic             r_start;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    // Completion pulses with nothing in flight are dropped here.
    assign o_ack   = i_done & r_busy;
    assign o_start = r_start;
    assign o_busy  = r_busy;
    assign o_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_start <= i_issue;
            if (i_clr) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                if (i_issue) begin
                    r_busy <= 1'b1;
                end else if (o_ack) begin
                    r_busy <= 1'b0;
                end
                if (o_ack) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tile_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tile_sched_ctrl
// Description : GEMM tile scheduler sequencing load, compute and store per tile
//               with ping-pong double-buffered inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_sched_ctrl
    import tpu_sched_pkg::*;
#(
    parameter int KMAX   = 1024,
    parameter int TIDX_W = c_tidx_w_def
) (
    input  logic              clk,
    input  logic              rst,
    tile_sched_ctrl_if.master bus
);

    localparam int c_cnt_w = 2 * TIDX_W;

    sched_state_e       r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_total, w_ld_cnt, w_cmp_cnt, w_st_cnt;
    logic [TIDX_W-1:0]  r_num_tn, r_ld_tm, r_ld_tn, r_st_tm, r_st_tn;
    logic [TIDX_W-1:0]  r_load_tm, r_load_tn, r_st_tm_out, r_st_tn_out;
    logic [15:0]        r_k_len;
    logic [1:0]         r_buf_full;
    logic               r_err, r_res_valid, r_load_buf, r_cmp_buf;
    logic               w_accept, w_k_bad, w_empty, w_run;
    logic               w_ld_issue, w_cmp_issue, w_st_issue;
    logic               w_ld_busy, w_cmp_busy, w_st_busy;
    logic               w_ld_ack, w_cmp_ack, w_st_ack;

    assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
    assign w_k_bad  = k_len_bad(bus.cmd_K_len, 32'(KMAX));
    assign w_empty  = (bus.cmd_num_tm == '0) || (bus.cmd_num_tn == '0);
    assign w_run    = (r_state == S_RUN);

    assign w_ld_issue  = w_run && !w_ld_busy && (w_ld_cnt < r_total) && !r_buf_full[w_ld_cnt[0]];
    assign w_cmp_issue = w_run && !w_cmp_busy && (w_cmp_cnt < w_ld_cnt) && !r_res_valid;
    assign w_st_issue  = w_run && !w_st_busy && r_res_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (w_k_bad || w_empty) ? S_FIN : S_RUN;
            S_RUN:   if (w_st_cnt == r_total) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= '0;
            r_num_tn <= '0;
            r_k_len <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_total  <= c_cnt_w'(bus.cmd_num_tm) * c_cnt_w'(bus.cmd_num_tn);
            r_num_tn <= bus.cmd_num_tn;
            r_k_len  <= bus.cmd_K_len;
            r_err    <= w_k_bad;
        end
    end

    // Row/column walkers track the tile each engine will handle next,
    // replacing t/num_tn and t%num_tn.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_buf_full  <= 2'b00;
            r_res_valid <= 1'b0;
            r_ld_tm     <= '0;
            r_ld_tn     <= '0;
            r_st_tm     <= '0;
            r_st_tn     <= '0;
        end else begin
            if (w_ld_ack) begin
                r_buf_full[w_ld_cnt[0]] <= 1'b1;
                if (r_ld_tn == r_num_tn - TIDX_W'(1)) begin
                    r_ld_tn <= '0;
                    r_ld_tm <= r_ld_tm + TIDX_W'(1);
                end else begin
                    r_ld_tn <= r_ld_tn + TIDX_W'(1);
                end
            end
            if (w_st_ack) begin
                r_res_valid <= 1'b0;
                if (r_st_tn == r_num_tn - TIDX_W'(1)) begin
                    r_st_tn <= '0;
                    r_st_tm <= r_st_tm + TIDX_W'(1);
                end else begin
                    r_st_tn <= r_st_tn + TIDX_W'(1);
                end
            end
            if (w_cmp_ack) begin
                r_buf_full[w_cmp_cnt[0]] <= 1'b0;
                r_res_valid              <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_tm   <= '0;
            r_load_tn   <= '0;
            r_load_buf  <= 1'b0;
            r_cmp_buf   <= 1'b0;
            r_st_tm_out <= '0;
            r_st_tn_out <= '0;
        end else begin
            if (w_ld_issue) begin
                r_load_tm  <= r_ld_tm;
                r_load_tn  <= r_ld_tn;
                r_load_buf <= w_ld_cnt[0];
            end
            if (w_cmp_issue) begin
                r_cmp_buf <= w_cmp_cnt[0];
            end
            if (w_st_issue) begin
                r_st_tm_out <= r_st_tm;
                r_st_tn_out <= r_st_tn;
            end
        end
    end

    sched_eng_slot #(.CNT_W(c_cnt_w)) u_ld_slot (
        .clk(clk), .rst(rst), .i_clr(w_accept), .i_issue(w_ld_issue), .i_done(bus.load_done),
        .o_start(bus.load_start), .o_busy(w_ld_busy), .o_ack(w_ld_ack), .o_cnt(w_ld_cnt)
    );

    sched_eng_slot #(.CNT_W(c_cnt_w)) u_cmp_slot (
        .clk(clk), .rst(rst), .i_clr(w_accept), .i_issue(w_cmp_issue), .i_done(bus.cmp_done),
        .o_start(bus.cmp_start), .o_busy(w_cmp_busy), .o_ack(w_cmp_ack), .o_cnt(w_cmp_cnt)
    );

    sched_eng_slot #(.CNT_W(c_cnt_w)) u_st_slot (
        .clk(clk), .rst(rst), .i_clr(w_accept), .i_issue(w_st_issue), .i_done(bus.st_done),
        .o_start(bus.st_start), .o_busy(w_st_busy), .o_ack(w_st_ack), .o_cnt(w_st_cnt)
    );

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_FIN);
    assign bus.err        = (r_state == S_FIN) && r_err;
    assign bus.load_K_len = r_k_len;
    assign bus.load_buf   = r_load_buf;
    assign bus.load_tm    = r_load_tm;
    assign bus.load_tn    = r_load_tn;
    assign bus.cmp_buf    = r_cmp_buf;
    assign bus.st_tm      = r_st_tm_out;
    assign bus.st_tn      = r_st_tn_out;

endmodule
`default_nettype wire

// File: tb/tb_tile_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_sched_ctrl
// Description : Directed self-checking bench for the GEMM tile scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_sched_ctrl;
    import tpu_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_sched_ctrl_if #(.TIDX_W(8)) ifc ();
    tile_sched_ctrl #(.KMAX(1024), .TIDX_W(8)) dut (.clk(clk), .rst(rst), .bus(ifc));

    logic ld_d = 1'b0, cmp_d = 1'b0, st_d = 1'b0, spur = 1'b0;
    assign ifc.load_done = ld_d | spur;
    assign ifc.cmp_done  = cmp_d | spur;
    assign ifc.st_done   = st_d | spur;

    int ld_lat = 1, cmp_lat = 1, st_lat = 1;
    int n_pass = 0, n_total = 0;

    // Engine models: done rises ld_lat cycles after the start cycle.
    initial forever begin
        @(posedge clk); #1;
        if (ifc.load_start) begin
            repeat (ld_lat) @(posedge clk); #1; ld_d = 1'b1;
            @(posedge clk); #1; ld_d = 1'b0;
        end
    end
    initial forever begin
        @(posedge clk); #1;
        if (ifc.cmp_start) begin
            repeat (cmp_lat) @(posedge clk); #1; cmp_d = 1'b1;
            @(posedge clk); #1; cmp_d = 1'b0;
        end
    end
    initial forever begin
        @(posedge clk); #1;
        if (ifc.st_start) begin
            repeat (st_lat) @(posedge clk); #1; st_d = 1'b1;
            @(posedge clk); #1; st_d = 1'b0;
        end
    end

    // Event recorder, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc_c = 0;
    int ld_n = 0, ldd_n = 0, cmp_n = 0, cmpd_n = 0, st_n = 0, std_n = 0, done_n = 0;
    int ld_c[256], ldd_c[256], cmp_c[256], cmpd_c[256], st_c[256], std_c[256], done_c[256];
    logic ld_b[256], cmp_b[256], done_busy[256], done_err[256];
    logic [7:0] ld_m[256], ld_t[256], st_m[256], st_t[256];
    logic [15:0] ld_k[256];

    always @(negedge clk) begin
        if (ifc.cmd_valid && ifc.cmd_ready) acc_c <= cyc;
        if (ifc.load_start) begin
            ld_c[ld_n] <= cyc; ld_b[ld_n] <= ifc.load_buf; ld_m[ld_n] <= ifc.load_tm;
            ld_t[ld_n] <= ifc.load_tn; ld_k[ld_n] <= ifc.load_K_len; ld_n <= ld_n + 1;
        end
        if (ifc.load_done) begin ldd_c[ldd_n] <= cyc; ldd_n <= ldd_n + 1; end
        if (ifc.cmp_start) begin cmp_c[cmp_n] <= cyc; cmp_b[cmp_n] <= ifc.cmp_buf; cmp_n <= cmp_n + 1; end
        if (ifc.cmp_done) begin cmpd_c[cmpd_n] <= cyc; cmpd_n <= cmpd_n + 1; end
        if (ifc.st_start) begin
            st_c[st_n] <= cyc; st_m[st_n] <= ifc.st_tm; st_t[st_n] <= ifc.st_tn; st_n <= st_n + 1;
        end
        if (ifc.st_done) begin std_c[std_n] <= cyc; std_n <= std_n + 1; end
        if (ifc.done) begin
            done_c[done_n] <= cyc; done_busy[done_n] <= ifc.busy; done_err[done_n] <= ifc.err;
            done_n <= done_n + 1;
        end
    end

    int b_ld, b_ldd, b_cmp, b_cmpd, b_st, b_std, b_done;

    task automatic snap();
        b_ld = ld_n; b_ldd = ldd_n; b_cmp = cmp_n; b_cmpd = cmpd_n;
        b_st = st_n; b_std = std_n; b_done = done_n;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] tm, input logic [7:0] tn, input logic [15:0] k);
        ifc.cmd_num_tm = tm; ifc.cmd_num_tn = tn; ifc.cmd_K_len = k; ifc.cmd_valid = 1'b1;
        tick(1);
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen);
        int k = 0;
        while (done_n == b_done && k < bound) begin tick(1); k++; end
        seen = (done_n != b_done);
    endtask

    task automatic test_reset();
        n_total++; if (ifc.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ifc.cmd_ready); else n_pass++;
        n_total++; if (ifc.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifc.busy); else n_pass++;
        n_total++; if (ifc.done !== 1'b0) $display("FAIL reset_done: got %b want 0", ifc.done); else n_pass++;
        n_total++; if (ifc.err !== 1'b0) $display("FAIL reset_err: got %b want 0", ifc.err); else n_pass++;
        n_total++; if ({ifc.load_start, ifc.cmp_start, ifc.st_start} !== 3'b000)
            $display("FAIL reset_starts: got %b want 000", {ifc.load_start, ifc.cmp_start, ifc.st_start}); else n_pass++;
        n_total++; if (ifc.load_K_len !== 16'd0) $display("FAIL reset_klen: got %0d want 0", ifc.load_K_len); else n_pass++;
        n_total++; if ({ifc.load_tm, ifc.load_tn, ifc.st_tm, ifc.st_tn} !== 32'd0)
            $display("FAIL reset_idx: got %h want 0", {ifc.load_tm, ifc.load_tn, ifc.st_tm, ifc.st_tn}); else n_pass++;
    endtask

    task automatic test_single();
        bit seen;
        ld_lat = 20; cmp_lat = 10; st_lat = 5;
        snap(); send(8'd1, 8'd1, 16'd4); wait_done(200, seen);
        n_total++; if (seen !== 1'b1) $display("FAIL single_done: got %b want 1", seen); else n_pass++;
        n_total++; if ({ld_n - b_ld, cmp_n - b_cmp, st_n - b_st} !== {32'd1, 32'd1, 32'd1})
            $display("FAIL single_starts: got %0d/%0d/%0d want 1/1/1", ld_n - b_ld, cmp_n - b_cmp, st_n - b_st); else n_pass++;
        n_total++; if ({ld_b[b_ld], cmp_b[b_cmp]} !== 2'b00) $display("FAIL single_bufs: got %b%b want 00", ld_b[b_ld], cmp_b[b_cmp]); else n_pass++;
        n_total++; if (ld_k[b_ld] !== 16'd4) $display("FAIL single_klen: got %0d want 4", ld_k[b_ld]); else n_pass++;
        n_total++; if (ld_c[b_ld] !== acc_c + 2) $display("FAIL single_ld_lat: got %0d want %0d", ld_c[b_ld], acc_c + 2); else n_pass++;
        n_total++; if (cmp_c[b_cmp] !== ldd_c[b_ldd] + 2) $display("FAIL single_cmp_lat: got %0d want %0d", cmp_c[b_cmp], ldd_c[b_ldd] + 2); else n_pass++;
        n_total++; if (st_c[b_st] !== cmpd_c[b_cmpd] + 2) $display("FAIL single_st_lat: got %0d want %0d", st_c[b_st], cmpd_c[b_cmpd] + 2); else n_pass++;
        n_total++; if (done_c[b_done] !== std_c[b_std] + 2) $display("FAIL single_done_lat: got %0d want %0d", done_c[b_done], std_c[b_std] + 2); else n_pass++;
        n_total++; if ({done_busy[b_done], done_err[b_done]} !== 2'b10)
            $display("FAIL single_done_flags: got busy=%b err=%b want busy=1 err=0", done_busy[b_done], done_err[b_done]); else n_pass++;
        n_total++; if ({ifc.busy, ifc.cmd_ready} !== 2'b01) $display("FAIL single_after: got busy=%b ready=%b want 0/1", ifc.busy, ifc.cmd_ready); else n_pass++;
    endtask

    task automatic test_grid_2x2();
        bit seen;
        ld_lat = 3; cmp_lat = 6; st_lat = 2;
        snap(); send(8'd2, 8'd2, 16'd16); wait_done(300, seen);
        n_total++; if (seen !== 1'b1) $display("FAIL grid_done: got %b want 1", seen); else n_pass++;
        n_total++; if (ld_n - b_ld !== 4) $display("FAIL grid_loads: got %0d want 4", ld_n - b_ld); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if ({ld_b[b_ld+i], ld_m[b_ld+i], ld_t[b_ld+i]} !== {i[0], 7'd0, i[1], 7'd0, i[0]})
                $display("FAIL grid_load%0d: got buf=%b tm=%0d tn=%0d want %0d/%0d/%0d", i, ld_b[b_ld+i], ld_m[b_ld+i], ld_t[b_ld+i], i % 2, i / 2, i % 2); else n_pass++;
            n_total++; if (cmp_b[b_cmp+i] !== i[0]) $display("FAIL grid_cmpbuf%0d: got %b want %0d", i, cmp_b[b_cmp+i], i % 2); else n_pass++;
            n_total++; if ({st_m[b_st+i], st_t[b_st+i]} !== {7'd0, i[1], 7'd0, i[0]})
                $display("FAIL grid_store%0d: got tm=%0d tn=%0d want %0d/%0d", i, st_m[b_st+i], st_t[b_st+i], i / 2, i % 2); else n_pass++;
        end
        n_total++; if (ld_c[b_ld+1] !== ldd_c[b_ldd] + 2) $display("FAIL grid_ld1_lat: got %0d want %0d", ld_c[b_ld+1], ldd_c[b_ldd] + 2); else n_pass++;
        n_total++; if (!(ld_c[b_ld+1] < cmpd_c[b_cmpd])) $display("FAIL grid_overlap: got load1 at %0d want before cmp0 end %0d", ld_c[b_ld+1], cmpd_c[b_cmpd]); else n_pass++;
        n_total++; if (ld_k[b_ld+3] !== 16'd16) $display("FAIL grid_klen: got %0d want 16", ld_k[b_ld+3]); else n_pass++;
    endtask

    task automatic test_ping_pong();
        bit seen;
        ld_lat = 5; cmp_lat = 100; st_lat = 1;
        snap(); send(8'd1, 8'd4, 16'd8); wait_done(1000, seen);
        n_total++; if (seen !== 1'b1) $display("FAIL pp_done: got %b want 1", seen); else n_pass++;
        n_total++; if (ld_n - b_ld !== 4) $display("FAIL pp_loads: got %0d want 4", ld_n - b_ld); else n_pass++;
        n_total++; if (ld_c[b_ld+2] !== cmpd_c[b_cmpd] + 2) $display("FAIL pp_ld2_lat: got %0d want %0d", ld_c[b_ld+2], cmpd_c[b_cmpd] + 2); else n_pass++;
        for (int k = 2; k < 4; k++) begin
            n_total++; if (!(ld_c[b_ld+k] > cmpd_c[b_cmpd+k-2]))
                $display("FAIL pp_depth%0d: got load at %0d want after cmp end %0d", k, ld_c[b_ld+k], cmpd_c[b_cmpd+k-2]); else n_pass++;
        end
    endtask

    task automatic test_store_block();
        bit seen;
        ld_lat = 2; cmp_lat = 3; st_lat = 50;
        snap(); send(8'd1, 8'd3, 16'd8); wait_done(1000, seen);
        n_total++; if (seen !== 1'b1) $display("FAIL sb_done: got %b want 1", seen); else n_pass++;
        n_total++; if (cmp_c[b_cmp+1] !== std_c[b_std] + 2) $display("FAIL sb_cmp1: got %0d want %0d", cmp_c[b_cmp+1], std_c[b_std] + 2); else n_pass++;
        n_total++; if ({st_n - b_st, 24'd0, st_t[b_st+2]} !== {32'd3, 32'd2})
            $display("FAIL sb_stores: got n=%0d last_tn=%0d want 3/2", st_n - b_st, st_t[b_st+2]); else n_pass++;
    endtask

    task automatic test_reject();
        logic [7:0]  tms[5]  = '{8'd2, 8'd2, 8'd0, 8'd3, 8'd1};
        logic [7:0]  tns[5]  = '{8'd2, 8'd2, 8'd4, 8'd0, 8'd1};
        logic [15:0] ks[5]   = '{16'd0, 16'd1025, 16'd4, 16'd4, 16'd1024};
        logic        errs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int          nl[5]   = '{0, 0, 0, 0, 1};
        bit seen;
        ld_lat = 1; cmp_lat = 1; st_lat = 1;
        for (int i = 0; i < 5; i++) begin
            snap(); send(tms[i], tns[i], ks[i]); wait_done(50, seen);
            n_total++; if (seen !== 1'b1) $display("FAIL rej%0d_done: got %b want 1", i, seen); else n_pass++;
            n_total++; if (done_err[b_done] !== errs[i]) $display("FAIL rej%0d_err: got %b want %b", i, done_err[b_done], errs[i]); else n_pass++;
            n_total++; if ({ld_n - b_ld, cmp_n - b_cmp, st_n - b_st} !== {nl[i], nl[i], nl[i]})
                $display("FAIL rej%0d_starts: got %0d/%0d/%0d want %0d each", i, ld_n - b_ld, cmp_n - b_cmp, st_n - b_st, nl[i]); else n_pass++;
            if (nl[i] == 0) begin
                n_total++; if (done_c[b_done] !== acc_c + 1) $display("FAIL rej%0d_lat: got %0d want %0d", i, done_c[b_done], acc_c + 1); else n_pass++;
            end
        end
    endtask

    task automatic test_spurious();
        bit seen;
        snap();
        spur = 1'b1; tick(1); spur = 1'b0; tick(4);
        n_total++; if ({ld_n - b_ld, cmp_n - b_cmp, st_n - b_st, done_n - b_done} !== 128'd0)
            $display("FAIL spur_idle: got %0d/%0d/%0d/%0d want 0 each", ld_n - b_ld, cmp_n - b_cmp, st_n - b_st, done_n - b_done); else n_pass++;
        n_total++; if (ifc.cmd_ready !== 1'b1) $display("FAIL spur_ready: got %b want 1", ifc.cmd_ready); else n_pass++;
        ld_lat = 2; cmp_lat = 2; st_lat = 2;
        snap(); send(8'd1, 8'd1, 16'd2); wait_done(100, seen);
        n_total++; if ({seen, 31'd0, ld_n - b_ld, st_n - b_st} !== {1'b1, 31'd0, 32'd1, 32'd1})
            $display("FAIL spur_cmd: got seen=%b loads=%0d stores=%0d want 1/1/1", seen, ld_n - b_ld, st_n - b_st); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        int k = 0;
        ld_lat = 4; cmp_lat = 4; st_lat = 4;
        snap(); send(8'd2, 8'd2, 16'd16);
        while (ld_n - b_ld < 3 && k < 200) begin tick(1); k++; end
        n_total++; if (ld_n - b_ld < 3) $display("FAIL rm_tile2: got %0d loads want 3", ld_n - b_ld); else n_pass++;
        rst = 1'b1; tick(1); rst = 1'b0;
        n_total++; if ({ifc.cmd_ready, ifc.busy, ifc.done, ifc.err} !== 4'b1000)
            $display("FAIL rm_status: got ready/busy/done/err=%b want 1000", {ifc.cmd_ready, ifc.busy, ifc.done, ifc.err}); else n_pass++;
        n_total++; if ({ifc.load_start, ifc.cmp_start, ifc.st_start, ifc.load_buf, ifc.load_K_len} !== 20'd0)
            $display("FAIL rm_outs: got %h want 0", {ifc.load_start, ifc.cmp_start, ifc.st_start, ifc.load_buf, ifc.load_K_len}); else n_pass++;
        snap(); tick(20);
        n_total++; if ({done_n - b_done, ld_n - b_ld} !== 64'd0)
            $display("FAIL rm_quiet: got done=%0d loads=%0d want 0/0", done_n - b_done, ld_n - b_ld); else n_pass++;
        ld_lat = 2; cmp_lat = 2; st_lat = 2;
        snap(); send(8'd1, 8'd1, 16'd8); wait_done(100, seen);
        n_total++; if (seen !== 1'b1) $display("FAIL rm_new_done: got %b want 1", seen); else n_pass++;
        n_total++; if ({ld_n - b_ld, 7'd0, ld_b[b_ld], ld_m[b_ld], ld_t[b_ld]} !== {32'd1, 24'd0})
            $display("FAIL rm_new_tile: got n=%0d buf=%b tm=%0d tn=%0d want 1/0/0/0", ld_n - b_ld, ld_b[b_ld], ld_m[b_ld], ld_t[b_ld]); else n_pass++;
        n_total++; if (done_err[b_done] !== 1'b0) $display("FAIL rm_new_err: got %b want 0", done_err[b_done]); else n_pass++;
    endtask

    initial begin
        ifc.cmd_valid = 1'b0; ifc.cmd_num_tm = '0; ifc.cmd_num_tn = '0; ifc.cmd_K_len = '0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        test_reset();
        test_single();
        test_grid_2x2();
        test_ping_pong();
        test_store_block();
        test_reject();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
